tap_controller: RTL and testbench

- IEEE 1149.1-style TAP controller and instruction register that sits directly upstream of the two-pin-input boundary-scan chip.
- Samples tms/tdi on tck and runs the 16-state TAP FSM.
- Generates the chip's scan controls: shift_dr, up_enable, mode, sel, bp_shift.
- Muxes the chip's serial output with its own IR shift path onto the board-level tdo.

---
 rtl/tap_controller_if.sv | 25 ++
 rtl/tap_controller.sv | 115 +++++++++++
 tb/tb_tap_controller.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_controller_if.sv
// Board-side TAP pins plus the scan controls handed to the boundary-scan chip.
// master = board/tester side, slave = tap_controller.
interface tap_controller_if;
    logic tms;
    logic tdi;
    logic chip_tdo;
    logic shift_dr;
    logic capture_dr;
    logic up_enable;
    logic mode;
    logic sel;
    logic bp_shift;
    logic tdo;
    logic tdo_en;

    modport master (
        output tms, tdi, chip_tdo,
        input  shift_dr, capture_dr, up_enable, mode, sel, bp_shift, tdo, tdo_en
    );

    modport slave (
        input  tms, tdi, chip_tdo,
        output shift_dr, capture_dr, up_enable, mode, sel, bp_shift, tdo, tdo_en
    );
endinterface

// File: rtl/tap_controller.sv
// 1149.1 TAP FSM and instruction register driving a two-pin boundary-scan chip.
// Optional macro TAP_IDCODE_EN adds opcode 10 = IDCODE with a 32-bit ID register.
module tap_controller #(
    parameter int unsigned IR_WIDTH     = 2,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic            tck,
    input  logic            trst_n,
    tap_controller_if.slave tap
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } state_e;

    localparam logic [1:0] OP_EXTEST = 2'b00;
    localparam logic [1:0] OP_SAMPLE = 2'b01;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = ~IR_WIDTH'(2'b10);
`ifdef TAP_IDCODE_EN
    localparam logic [1:0]          OP_IDCODE = 2'b10;
    localparam logic [IR_WIDTH-1:0] IR_RESET  = ~IR_WIDTH'(2'b01);
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET  = '1;
`endif

    state_e              state_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_sr_q;
    logic [1:0]          opcode;
    logic                enter_tlr;
    logic                dr_tdo;

    // TAP state machine, advanced on tms every rising tck
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            state_q <= TLR;
        end else begin
            case (state_q)
                TLR:     state_q <= tap.tms ? TLR    : RTI;
                RTI:     state_q <= tap.tms ? SEL_DR : RTI;
                SEL_DR:  state_q <= tap.tms ? SEL_IR : CAP_DR;
                CAP_DR:  state_q <= tap.tms ? EX1_DR : SH_DR;
                SH_DR:   state_q <= tap.tms ? EX1_DR : SH_DR;
                EX1_DR:  state_q <= tap.tms ? UPD_DR : PA_DR;
                PA_DR:   state_q <= tap.tms ? EX2_DR : PA_DR;
                EX2_DR:  state_q <= tap.tms ? UPD_DR : SH_DR;
                UPD_DR:  state_q <= tap.tms ? SEL_DR : RTI;
                SEL_IR:  state_q <= tap.tms ? TLR    : CAP_IR;
                CAP_IR:  state_q <= tap.tms ? EX1_IR : SH_IR;
                SH_IR:   state_q <= tap.tms ? EX1_IR : SH_IR;
                EX1_IR:  state_q <= tap.tms ? UPD_IR : PA_IR;
                PA_IR:   state_q <= tap.tms ? EX2_IR : PA_IR;
                EX2_IR:  state_q <= tap.tms ? UPD_IR : SH_IR;
                UPD_IR:  state_q <= tap.tms ? SEL_DR : RTI;
                default: state_q <= TLR;
            endcase
        end
    end

    // Only TLR (holding) and SEL_IR lead into TLR; the IR is reloaded on that edge.
    assign enter_tlr = tap.tms && ((state_q == TLR) || (state_q == SEL_IR));

    always_ff @(posedge tck) begin
        if (!trst_n) begin
            ir_q    <= IR_RESET;
            ir_sr_q <= '1;
        end else begin
            case (state_q)
                CAP_IR:  ir_sr_q <= IR_CAPTURE;
                SH_IR:   ir_sr_q <= {tap.tdi, ir_sr_q[IR_WIDTH-1:1]};
                default: ir_sr_q <= ir_sr_q;
            endcase
            if (enter_tlr) begin
                ir_q <= IR_RESET;
            end else if (state_q == UPD_IR) begin
                ir_q <= ir_sr_q;
            end
        end
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] id_q;

    always_ff @(posedge tck) begin
        if (!trst_n) begin
            id_q <= '0;
        end else if (state_q == CAP_DR) begin
            id_q <= IDCODE_VALUE;
        end else if (state_q == SH_DR) begin
            id_q <= {tap.tdi, id_q[31:1]};
        end
    end

    assign dr_tdo = (opcode == OP_IDCODE) ? id_q[0] : tap.chip_tdo;
`else
    logic unused_idcode;
    assign unused_idcode = ^IDCODE_VALUE;
    assign dr_tdo        = tap.chip_tdo;
`endif

    assign opcode = ir_q[1:0];

    // Scan controls decoded straight from state and IR
    assign tap.shift_dr   = (state_q == SH_DR);
    assign tap.capture_dr = (state_q == CAP_DR);
    assign tap.up_enable  = (state_q == UPD_DR);
    assign tap.mode       = (opcode == OP_EXTEST);
    assign tap.sel        = !((opcode == OP_EXTEST) || (opcode == OP_SAMPLE));
    assign tap.bp_shift   = tap.shift_dr && tap.sel;
    assign tap.tdo_en     = (state_q == SH_IR) || (state_q == SH_DR);
    assign tap.tdo        = (state_q == SH_IR) ? ir_sr_q[0] :
                            (state_q == SH_DR) ? dr_tdo     : 1'b0;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller with a table-driven reference model checked every cycle.
module tb_tap_controller;
    localparam int unsigned IR_WIDTH     = 2;
    localparam logic [31:0] IDCODE_VALUE = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
    localparam int RST_OP = 2;
    localparam bit ID_EN  = 1'b1;
`else
    localparam int RST_OP = 3;
    localparam bit ID_EN  = 1'b0;
`endif

    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7, UDR = 8;
    localparam int SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    logic tck    = 1'b0;
    logic trst_n = 1'b0;
    tap_controller_if tap();

    tap_controller #(.IR_WIDTH(IR_WIDTH), .IDCODE_VALUE(IDCODE_VALUE)) dut (
        .tck(tck), .trst_n(trst_n), .tap(tap)
    );

    always #5 tck = ~tck;

    int checks = 0;
    int errors = 0;
    int sd_cnt = 0, cd_cnt = 0, ue_cnt = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: next-state table, IR as an integer opcode, shift reg as a bit queue (LSB first)
    int          nxt[16][2];
    int          m_state;
    int          m_ir;
    bit          m_sr[$];
    logic [31:0] m_id;
    bit          m_valid = 1'b0;

    initial begin
        nxt[TLR]  = '{RTI, TLR};   nxt[RTI]  = '{RTI, SDR};
        nxt[SDR]  = '{CDR, SIR};   nxt[SIR]  = '{CIR, TLR};
        nxt[CDR]  = '{SHDR, E1DR}; nxt[CIR]  = '{SHIR, E1IR};
        nxt[SHDR] = '{SHDR, E1DR}; nxt[SHIR] = '{SHIR, E1IR};
        nxt[E1DR] = '{PDR, UDR};   nxt[E1IR] = '{PIR, UIR};
        nxt[PDR]  = '{PDR, E2DR};  nxt[PIR]  = '{PIR, E2IR};
        nxt[E2DR] = '{SHDR, UDR};  nxt[E2IR] = '{SHIR, UIR};
        nxt[UDR]  = '{RTI, SDR};   nxt[UIR]  = '{RTI, SDR};
    end

    always @(posedge tck) begin
        if (!trst_n) begin
            m_state = TLR;
            m_ir    = RST_OP;
            m_sr    = '{1'b1, 1'b1};
            m_id    = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            int ns;
            ns = nxt[m_state][tap.tms ? 1 : 0];
            if (m_state == CIR) begin
                m_sr = '{1'b1, 1'b0};
            end else if (m_state == SHIR) begin
                void'(m_sr.pop_front());
                m_sr.push_back(tap.tdi);
            end
            if (m_state == UIR) m_ir = int'(m_sr[0]) + 2 * int'(m_sr[1]);
            if (m_state == CDR) m_id = IDCODE_VALUE;
            else if (m_state == SHDR) m_id = {tap.tdi, m_id[31:1]};
            if (ns == TLR) m_ir = RST_OP;
            m_state = ns;
        end
    end

    // Compare every output on the falling edge, mid-cycle
    always @(negedge tck) begin
        if (m_valid) begin
            int   op;
            logic e_sel, e_tdo;
            op    = m_ir % 4;
            e_sel = !(op == 0 || op == 1);
            if (m_state == SHIR)      e_tdo = m_sr[0];
            else if (m_state == SHDR) e_tdo = (ID_EN && op == 2) ? m_id[0] : tap.chip_tdo;
            else                      e_tdo = 1'b0;
            chk("shift_dr",   tap.shift_dr,   m_state == SHDR);
            chk("capture_dr", tap.capture_dr, m_state == CDR);
            chk("up_enable",  tap.up_enable,  m_state == UDR);
            chk("mode",       tap.mode,       op == 0);
            chk("sel",        tap.sel,        e_sel);
            chk("bp_shift",   tap.bp_shift,   (m_state == SHDR) && e_sel);
            chk("tdo_en",     tap.tdo_en,     (m_state == SHDR) || (m_state == SHIR));
            chk("tdo",        tap.tdo,        e_tdo);
        end
    end

    // One tck: inputs apply at the next rising edge, return 2 time units after it
    task automatic tick(input logic t, input logic d = 1'b0, input logic c = 1'b0);
        tap.tms      = t;
        tap.tdi      = d;
        tap.chip_tdo = c;
        @(posedge tck);
        #2;
        sd_cnt += int'(tap.shift_dr);
        cd_cnt += int'(tap.capture_dr);
        ue_cnt += int'(tap.up_enable);
    endtask

    task automatic clr_cnt();
        sd_cnt = 0;
        cd_cnt = 0;
        ue_cnt = 0;
    endtask

    // From RTI: load IR = {b1, b0} and return to RTI
    task automatic load_ir(input logic b0, input logic b1);
        tick(1); tick(1); tick(0); tick(0);
        tick(0, b0); tick(1, b1); tick(1); tick(0);
    endtask

    logic [5:0]  pat = 6'b101100;
    logic [31:0] got;

    initial begin
        tap.tms = 1'b0; tap.tdi = 1'b0; tap.chip_tdo = 1'b0;
        trst_n  = 1'b0;
        tick(1); tick(0);
        chk("rst_sel", tap.sel, 1'b1);
        chk("rst_mode", tap.mode, 1'b0);
        chk("rst_shift_dr", tap.shift_dr, 1'b0);
        chk("rst_up_enable", tap.up_enable, 1'b0);
        chk("rst_tdo_en", tap.tdo_en, 1'b0);
        chk("rst_tdo", tap.tdo, 1'b0);
        trst_n = 1'b1;
        tick(0);

        // IR scan loading EXTEST, observing capture pattern 01
        clr_cnt();
        tick(1); tick(1); tick(0); tick(0);
        chk("ir_cap_bit0", tap.tdo, 1'b1);
        chk("ir_tdo_en", tap.tdo_en, 1'b1);
        tick(0, 0);
        chk("ir_cap_bit1", tap.tdo, 1'b0);
        tick(1, 0); tick(1);
        chk("ir_upd_mode_pending", tap.mode, 1'b0);
        tick(0);
        chk_int("ir_no_up_enable", ue_cnt, 0);
        chk("extest_mode", tap.mode, 1'b1);
        chk("extest_sel", tap.sel, 1'b0);

        // EXTEST DR scan: 7 shift cycles
        clr_cnt();
        tick(1); tick(0);
        chk("dr_capture", tap.capture_dr, 1'b1);
        tick(0, 0, 1);
        chk("dr_tdo_chip", tap.tdo, 1'b1);
        for (int i = 0; i < 6; i++) tick(0, 0, pat[i]);
        tick(1); tick(1);
        chk("dr_up_enable", tap.up_enable, 1'b1);
        tick(0);
        chk_int("dr_shift_cnt", sd_cnt, 7);
        chk_int("dr_capture_cnt", cd_cnt, 1);
        chk_int("dr_update_cnt", ue_cnt, 1);

        // BYPASS
        load_ir(1, 1);
        chk("bypass_sel", tap.sel, 1'b1);
        chk("bypass_mode", tap.mode, 1'b0);
        tick(1); tick(0); tick(0, 0, 1);
        chk("bypass_bp_shift", tap.bp_shift, 1'b1);
        chk("bypass_shift_dr", tap.shift_dr, 1'b1);
        tick(1); tick(1); tick(0);

        // SAMPLE_PRELOAD, then five tms=1 out of SH_DR
        load_ir(1, 0);
        chk("sample_sel", tap.sel, 1'b0);
        chk("sample_mode", tap.mode, 1'b0);
        tick(1); tick(0); tick(0, 1, 0);
        chk("sample_bp_shift", tap.bp_shift, 1'b0);
        clr_cnt();
        for (int i = 0; i < 5; i++) tick(1);
        chk_int("tms5_up_enable", ue_cnt, 1);
        chk("tms5_sel", tap.sel, 1'b1);
        chk("tms5_mode", tap.mode, 1'b0);
        chk("tms5_tdo_en", tap.tdo_en, 1'b0);
        tick(0);

        // Opcode 10 (BYPASS, or IDCODE when enabled)
        load_ir(0, 1);
        chk("op10_sel", tap.sel, 1'b1);
        chk("op10_mode", tap.mode, 1'b0);
        tick(1); tick(0);
        for (int i = 0; i < 6; i++) tick(0, pat[i], pat[5-i]);
        tick(1); tick(1); tick(0);

        // Reset mid IR shift, after EXTEST is loaded
        load_ir(0, 0);
        chk("pre_abort_mode", tap.mode, 1'b1);
        clr_cnt();
        tick(1); tick(1); tick(0); tick(0); tick(0, 0);
        trst_n = 1'b0;
        tick(1);
        chk("abort_tdo_en", tap.tdo_en, 1'b0);
        chk("abort_mode", tap.mode, 1'b0);
        chk("abort_sel", tap.sel, 1'b1);
        chk_int("abort_up_enable", ue_cnt, 0);
        trst_n = 1'b1;
        tick(0);

`ifdef TAP_IDCODE_EN
        // IDCODE streamed LSB first after reset
        trst_n = 1'b0;
        tick(0);
        trst_n = 1'b1;
        tick(0); tick(1); tick(0); tick(0);
        got    = '0;
        got[0] = tap.tdo;
        for (int i = 1; i < 32; i++) begin
            tick(0);
            got[i] = tap.tdo;
        end
        checks++;
        if (got !== 32'h1000_0001) begin
            errors++;
            $display("FAIL idcode_stream: got %h expected %h", got, 32'h1000_0001);
        end
        tick(1); tick(1); tick(0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
